// File: rtl/tlb_pkg.sv
// Shared TLB definitions: field widths, cache attribute codes, page and key payloads.
package tlb_pkg;

  localparam int unsigned VPN2_W = 19;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned C_W    = 3;

  // Cache attribute codes, kept identical to the ones cp0 uses
  localparam logic [C_W-1:0] CACHE_UNCACHED = 3'd2;
  localparam logic [C_W-1:0] CACHE_CACHED   = 3'd3;

  // One half (even or odd page) of a TLB entry
  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  // Lookup key presented by a search port
  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              odd_page;
  } key_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational TLB search: per-entry compare, lowest-index priority encode, page-half select.
// Optional TLB_MULTI_HIT_EN adds a two-or-more-match detector.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int unsigned TLBNUM       = 16,
  parameter int unsigned TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic [TLBNUM-1:0][VPN2_W-1:0] vpn2_i,
  input  logic [TLBNUM-1:0][ASID_W-1:0] asid_i,
  input  logic [TLBNUM-1:0]             g_i,
  input  page_t [TLBNUM-1:0]            page0_i,
  input  page_t [TLBNUM-1:0]            page1_i,
  input  key_t                          key_i,
`ifdef TLB_MULTI_HIT_EN
  output logic                          multi_hit_o,
`endif
  output logic                          found_o,
  output logic [TLBNUM_WIDTH-1:0]       index_o,
  output page_t                         page_o
);

  logic [TLBNUM-1:0] match_c;

  // Tag compare per entry; global entries ignore the ASID
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(TLBNUM); i++) begin
      match_c[i] = (vpn2_i[i] == key_i.vpn2) && (g_i[i] || (asid_i[i] == key_i.asid));
    end
  end

  // Lowest matching index wins; page half picked by VA[12]
  always_comb begin
    found_o = |match_c;
    index_o = '0;
    page_o  = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (match_c[i]) index_o = TLBNUM_WIDTH'(i);
    end
    if (found_o) page_o = key_i.odd_page ? page1_i[index_o] : page0_i[index_o];
  end

`ifdef TLB_MULTI_HIT_EN
  // Clearing the lowest set bit leaves something only when two or more entries match
  assign multi_hit_o = |(match_c & (match_c - TLBNUM'(1)));
`endif

endmodule

// File: rtl/tlb.sv
// Joint TLB array beside cp0: write port, combinational read port, two registered
// search ports with hold and stale tracking. Optional macro: TLB_MULTI_HIT_EN.
module tlb
  import tlb_pkg::*;
#(
  parameter int unsigned TLBNUM       = 16,
  parameter int unsigned TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_req,
  input  logic                    s0_hold,
  input  logic [VPN2_W-1:0]       s0_vpn2,
  input  logic                    s0_odd_page,
  input  logic [ASID_W-1:0]       s0_asid,
  output logic                    s0_valid,
  output logic                    s0_found,
  output logic [TLBNUM_WIDTH-1:0] s0_index,
  output logic [PFN_W-1:0]        s0_pfn,
  output logic [C_W-1:0]          s0_c,
  output logic                    s0_d,
  output logic                    s0_v,
  output logic                    s0_stale,
`ifdef TLB_MULTI_HIT_EN
  output logic                    s0_multi_hit,
  output logic                    s1_multi_hit,
`endif
  input  logic                    s1_req,
  input  logic                    s1_hold,
  input  logic [VPN2_W-1:0]       s1_vpn2,
  input  logic                    s1_odd_page,
  input  logic [ASID_W-1:0]       s1_asid,
  output logic                    s1_valid,
  output logic                    s1_found,
  output logic [TLBNUM_WIDTH-1:0] s1_index,
  output logic [PFN_W-1:0]        s1_pfn,
  output logic [C_W-1:0]          s1_c,
  output logic                    s1_d,
  output logic                    s1_v,
  output logic                    s1_stale,
  output logic [TLBNUM_WIDTH:0]   tlbp_result,
  input  logic                    we,
  input  logic [TLBNUM_WIDTH-1:0] w_index,
  input  logic [VPN2_W-1:0]       w_vpn2,
  input  logic [ASID_W-1:0]       w_asid,
  input  logic                    w_g,
  input  logic [PFN_W-1:0]        w_pfn0,
  input  logic [C_W-1:0]          w_c0,
  input  logic                    w_d0,
  input  logic                    w_v0,
  input  logic [PFN_W-1:0]        w_pfn1,
  input  logic [C_W-1:0]          w_c1,
  input  logic                    w_d1,
  input  logic                    w_v1,
  input  logic [TLBNUM_WIDTH-1:0] r_index,
  output logic [VPN2_W-1:0]       r_vpn2,
  output logic [ASID_W-1:0]       r_asid,
  output logic                    r_g,
  output logic [PFN_W-1:0]        r_pfn0,
  output logic [C_W-1:0]          r_c0,
  output logic                    r_d0,
  output logic                    r_v0,
  output logic [PFN_W-1:0]        r_pfn1,
  output logic [C_W-1:0]          r_c1,
  output logic                    r_d1,
  output logic                    r_v1
);

  logic [TLBNUM-1:0][VPN2_W-1:0] vpn2_q;
  logic [TLBNUM-1:0][ASID_W-1:0] asid_q;
  logic [TLBNUM-1:0]             g_q;
  page_t [TLBNUM-1:0]            page0_q;
  page_t [TLBNUM-1:0]            page1_q;

  // Entry storage; a write lands at the edge, so same-cycle searches see old contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpn2_q  <= '0;
      asid_q  <= '0;
      g_q     <= '0;
      page0_q <= '0;
      page1_q <= '0;
    end else if (we) begin
      vpn2_q[w_index]  <= w_vpn2;
      asid_q[w_index]  <= w_asid;
      g_q[w_index]     <= w_g;
      page0_q[w_index] <= {w_pfn0, w_c0, w_d0, w_v0};
      page1_q[w_index] <= {w_pfn1, w_c1, w_d1, w_v1};
    end
  end

  // Read port is combinational so cp0 can capture it in the tlbr cycle
  assign r_vpn2 = vpn2_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign {r_pfn0, r_c0, r_d0, r_v0} = page0_q[r_index];
  assign {r_pfn1, r_c1, r_d1, r_v1} = page1_q[r_index];

  logic [1:0] req_c;
  logic [1:0] hold_c;
  key_t [1:0] key_c;

  assign req_c    = {s1_req, s0_req};
  assign hold_c   = {s1_hold, s0_hold};
  assign key_c[0] = {s0_vpn2, s0_asid, s0_odd_page};
  assign key_c[1] = {s1_vpn2, s1_asid, s1_odd_page};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                    m_found;
    logic [TLBNUM_WIDTH-1:0] m_index;
    page_t                   m_page;
    logic                    valid_q, valid_d;
    logic                    found_q, found_d;
    logic                    stale_q, stale_d;
    logic [TLBNUM_WIDTH-1:0] index_q, index_d;
    page_t                   page_q, page_d;
`ifdef TLB_MULTI_HIT_EN
    logic                    m_multi;
    logic                    multi_q, multi_d;
`endif

    tlb_match #(
      .TLBNUM       (TLBNUM),
      .TLBNUM_WIDTH (TLBNUM_WIDTH)
    ) u_match (
      .vpn2_i      (vpn2_q),
      .asid_i      (asid_q),
      .g_i         (g_q),
      .page0_i     (page0_q),
      .page1_i     (page1_q),
      .key_i       (key_c[p]),
`ifdef TLB_MULTI_HIT_EN
      .multi_hit_o (m_multi),
`endif
      .found_o     (m_found),
      .index_o     (m_index),
      .page_o      (m_page)
    );

    // Result register next state: hold freezes (and may go stale), req loads, idle drops valid
    always_comb begin
      valid_d = valid_q;
      found_d = found_q;
      index_d = index_q;
      page_d  = page_q;
      stale_d = stale_q;
`ifdef TLB_MULTI_HIT_EN
      multi_d = multi_q;
`endif
      if (hold_c[p]) begin
        if (we && valid_q) stale_d = 1'b1;
      end else if (req_c[p]) begin
        valid_d = 1'b1;
        found_d = m_found;
        index_d = m_index;
        page_d  = m_page;
        stale_d = 1'b0;
`ifdef TLB_MULTI_HIT_EN
        multi_d = m_multi;
`endif
      end else begin
        valid_d = 1'b0;
        stale_d = 1'b0;
      end
    end

    // Result register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        found_q <= 1'b0;
        index_q <= '0;
        page_q  <= '0;
        stale_q <= 1'b0;
`ifdef TLB_MULTI_HIT_EN
        multi_q <= 1'b0;
`endif
      end else begin
        valid_q <= valid_d;
        found_q <= found_d;
        index_q <= index_d;
        page_q  <= page_d;
        stale_q <= stale_d;
`ifdef TLB_MULTI_HIT_EN
        multi_q <= multi_d;
`endif
      end
    end
  end

  assign s0_valid = g_port[0].valid_q;
  assign s0_found = g_port[0].found_q;
  assign s0_index = g_port[0].index_q;
  assign s0_stale = g_port[0].stale_q;
  assign {s0_pfn, s0_c, s0_d, s0_v} = g_port[0].page_q;
  assign s1_valid = g_port[1].valid_q;
  assign s1_found = g_port[1].found_q;
  assign s1_index = g_port[1].index_q;
  assign s1_stale = g_port[1].stale_q;
  assign {s1_pfn, s1_c, s1_d, s1_v} = g_port[1].page_q;
`ifdef TLB_MULTI_HIT_EN
  assign s0_multi_hit = g_port[0].multi_q;
  assign s1_multi_hit = g_port[1].multi_q;
`endif

  // tlbp probe result: miss flag on top, index forced to zero on a miss
  assign tlbp_result = {~s1_found, s1_found ? s1_index : TLBNUM_WIDTH'(0)};

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: write/read, lookup, global, tlbp, write hazard, hold/stale,
// async reset and duplicate entries.
module tb_tlb;
  import tlb_pkg::*;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  logic s0_req, s0_hold, s0_odd_page, s1_req, s1_hold, s1_odd_page;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic [7:0] s0_asid, s1_asid;
  logic s0_valid, s0_found, s0_d, s0_v, s0_stale;
  logic s1_valid, s1_found, s1_d, s1_v, s1_stale;
  logic [W-1:0] s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0] s0_c, s1_c;
  logic [W:0] tlbp_result;
  logic we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [W-1:0] w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0] w_asid, r_asid;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0] w_c0, w_c1, r_c0, r_c1;
  logic r_g, r_d0, r_v0, r_d1, r_v1;
`ifdef TLB_MULTI_HIT_EN
  logic s0_multi_hit, s1_multi_hit;
`endif

  int total = 0;
  int bad = 0;

  tlb #(.TLBNUM(N), .TLBNUM_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_hold(s0_hold), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page),
    .s0_asid(s0_asid), .s0_valid(s0_valid), .s0_found(s0_found), .s0_index(s0_index),
    .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v), .s0_stale(s0_stale),
`ifdef TLB_MULTI_HIT_EN
    .s0_multi_hit(s0_multi_hit), .s1_multi_hit(s1_multi_hit),
`endif
    .s1_req(s1_req), .s1_hold(s1_hold), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page),
    .s1_asid(s1_asid), .s1_valid(s1_valid), .s1_found(s1_found), .s1_index(s1_index),
    .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v), .s1_stale(s1_stale),
    .tlbp_result(tlbp_result),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present write-port fields (strobe controlled by caller)
  task automatic set_w(input logic [W-1:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                       input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                       input logic v0, input logic [19:0] pfn1, input logic [2:0] c1,
                       input logic v1);
    w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = v0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = v1; w_v1 = v1;
  endtask

  task automatic wr(input logic [W-1:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic [2:0] c0, input logic v0,
                    input logic [19:0] pfn1, input logic [2:0] c1, input logic v1);
    set_w(idx, vpn2, asid, g, pfn0, c0, v0, pfn1, c1, v1);
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  // One-cycle s0 lookup; result is visible on return
  task automatic look0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    s0_req = 1'b1; s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
    tick();
    s0_req = 1'b0;
  endtask

  task automatic look1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    s1_req = 1'b1; s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
    tick();
    s1_req = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({s0_valid, s0_found, s0_stale, s0_index, s0_pfn} !== 27'h0) begin
      bad++; $display("FAIL reset_s0 got=%h exp=0", {s0_valid, s0_found, s0_stale, s0_index, s0_pfn});
    end
    total++;
    if ({s1_valid, s1_found, s1_stale, tlbp_result} !== 8'h10) begin
      bad++; $display("FAIL reset_s1 got=%h exp=10", {s1_valid, s1_found, s1_stale, tlbp_result});
    end
  endtask

  task automatic test_lookup();
    wr(4'd3, 19'h00012, 8'd5, 1'b0, 20'h11111, CACHE_UNCACHED, 1'b1, 20'hABCDE, CACHE_CACHED, 1'b1);
    r_index = 4'd3;
    #1;
    total++;
    if ({r_vpn2, r_asid, r_g, r_pfn1, r_c1, r_v1} !== {19'h00012, 8'd5, 1'b0, 20'hABCDE, 3'd3, 1'b1}) begin
      bad++; $display("FAIL read_port got=%h/%h/%h/%h", r_vpn2, r_asid, r_g, r_pfn1);
    end
    look0(19'h00012, 1'b1, 8'd5);
    total++;
    if ({s0_valid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== {1'b1, 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1}) begin
      bad++; $display("FAIL lookup_odd got v=%b f=%b i=%0d pfn=%h c=%0d", s0_valid, s0_found, s0_index, s0_pfn, s0_c);
    end
    look0(19'h00012, 1'b0, 8'd5);
    total++;
    if ({s0_found, s0_pfn, s0_c} !== {1'b1, 20'h11111, 3'd2}) begin
      bad++; $display("FAIL lookup_even got f=%b pfn=%h c=%0d exp pfn=11111 c=2", s0_found, s0_pfn, s0_c);
    end
    look0(19'h00012, 1'b1, 8'd6);
    total++;
    if ({s0_valid, s0_found} !== 2'b10) begin
      bad++; $display("FAIL asid_miss got v=%b f=%b exp v=1 f=0", s0_valid, s0_found);
    end
    tick();
    total++;
    if (s0_valid !== 1'b0) begin
      bad++; $display("FAIL idle_drop got=%b exp=0", s0_valid);
    end
  endtask

  task automatic test_global();
    wr(4'd3, 19'h00012, 8'd5, 1'b1, 20'h11111, CACHE_UNCACHED, 1'b1, 20'hABCDE, CACHE_CACHED, 1'b1);
    look0(19'h00012, 1'b1, 8'hFF);
    total++;
    if ({s0_found, s0_index} !== {1'b1, 4'd3}) begin
      bad++; $display("FAIL global_hit got f=%b i=%0d exp f=1 i=3", s0_found, s0_index);
    end
    look1(19'h00012, 1'b0, 8'h77);
    total++;
    if (tlbp_result !== 5'b0_0011) begin
      bad++; $display("FAIL tlbp_hit got=%b exp=00011", tlbp_result);
    end
    look1(19'h00099, 1'b0, 8'h77);
    total++;
    if (tlbp_result !== 5'b1_0000) begin
      bad++; $display("FAIL tlbp_miss got=%b exp=10000", tlbp_result);
    end
  endtask

  task automatic test_hazard();
    set_w(4'd7, 19'h00040, 8'd1, 1'b0, 20'h07070, CACHE_CACHED, 1'b1, 20'h17171, CACHE_CACHED, 1'b1);
    we = 1'b1;
    s1_req = 1'b1; s1_vpn2 = 19'h00040; s1_odd_page = 1'b0; s1_asid = 8'd1;
    tick();
    we = 1'b0;
    total++;
    if ({s1_valid, s1_found} !== 2'b10) begin
      bad++; $display("FAIL hazard_old got v=%b f=%b exp v=1 f=0", s1_valid, s1_found);
    end
    tick();
    s1_req = 1'b0;
    total++;
    if ({s1_found, s1_index, s1_pfn} !== {1'b1, 4'd7, 20'h07070}) begin
      bad++; $display("FAIL hazard_new got f=%b i=%0d pfn=%h exp 1/7/07070", s1_found, s1_index, s1_pfn);
    end
    tick();
  endtask

  task automatic test_stale();
    look0(19'h00012, 1'b1, 8'd0);
    s0_hold = 1'b1; s0_req = 1'b1; s0_vpn2 = 19'h00099;
    tick();
    s0_req = 1'b0;
    total++;
    if ({s0_valid, s0_found, s0_pfn, s0_stale} !== {1'b1, 1'b1, 20'hABCDE, 1'b0}) begin
      bad++; $display("FAIL hold_ignores_req got v=%b f=%b pfn=%h st=%b", s0_valid, s0_found, s0_pfn, s0_stale);
    end
    wr(4'd3, 19'h00012, 8'd5, 1'b1, 20'h11111, CACHE_UNCACHED, 1'b1, 20'h12345, CACHE_CACHED, 1'b1);
    total++;
    if ({s0_valid, s0_stale, s0_pfn, s1_stale} !== {1'b1, 1'b1, 20'hABCDE, 1'b0}) begin
      bad++; $display("FAIL stale_set got v=%b st=%b pfn=%h s1st=%b", s0_valid, s0_stale, s0_pfn, s1_stale);
    end
    tick();
    total++;
    if (s0_stale !== 1'b1) begin
      bad++; $display("FAIL stale_persist got=%b exp=1", s0_stale);
    end
    s0_hold = 1'b0;
    look0(19'h00012, 1'b1, 8'd0);
    total++;
    if ({s0_valid, s0_stale, s0_pfn} !== {1'b1, 1'b0, 20'h12345}) begin
      bad++; $display("FAIL stale_reload got v=%b st=%b pfn=%h exp 1/0/12345", s0_valid, s0_stale, s0_pfn);
    end
    tick();
  endtask

  task automatic test_dup();
    wr(4'd9, 19'h00055, 8'd1, 1'b1, 20'h99999, CACHE_CACHED, 1'b1, 20'h99990, CACHE_CACHED, 1'b1);
    wr(4'd2, 19'h00055, 8'd1, 1'b1, 20'h22222, CACHE_CACHED, 1'b1, 20'h22220, CACHE_CACHED, 1'b1);
    look0(19'h00055, 1'b0, 8'd3);
    total++;
    if ({s0_found, s0_index, s0_pfn} !== {1'b1, 4'd2, 20'h22222}) begin
      bad++; $display("FAIL dup_lowest got f=%b i=%0d pfn=%h exp 1/2/22222", s0_found, s0_index, s0_pfn);
    end
`ifdef TLB_MULTI_HIT_EN
    total++;
    if (s0_multi_hit !== 1'b1) begin
      bad++; $display("FAIL multi_hit got=%b exp=1", s0_multi_hit);
    end
    look0(19'h00040, 1'b0, 8'd1);
    total++;
    if ({s0_found, s0_multi_hit} !== 2'b10) begin
      bad++; $display("FAIL single_hit got f=%b m=%b exp 1/0", s0_found, s0_multi_hit);
    end
`endif
    tick();
  endtask

  task automatic test_async_reset();
    look0(19'h00012, 1'b1, 8'd5);
    s0_hold = 1'b1;
    wr(4'd5, 19'h00333, 8'd2, 1'b0, 20'h5, CACHE_CACHED, 1'b1, 20'h6, CACHE_CACHED, 1'b1);
    total++;
    if ({s0_valid, s0_found, s0_stale} !== 3'b111) begin
      bad++; $display("FAIL pre_reset got=%b exp=111", {s0_valid, s0_found, s0_stale});
    end
    #3 reset = 1'b1;
    #1;
    total++;
    if ({s0_valid, s0_found, s0_stale, s0_index, s0_pfn} !== 27'h0) begin
      bad++; $display("FAIL async_reset got=%h exp=0", {s0_valid, s0_found, s0_stale, s0_index, s0_pfn});
    end
    #1 reset = 1'b0;
    s0_hold = 1'b0;
    tick();
    look0(19'h00012, 1'b1, 8'd5);
    r_index = 4'd3;
    #1;
    total++;
    if ({s0_found, s0_v, r_v1, r_vpn2} !== {1'b0, 1'b0, 1'b0, 19'h0}) begin
      bad++; $display("FAIL wiped_entry got f=%b v=%b rv1=%b rvpn2=%h", s0_found, s0_v, r_v1, r_vpn2);
    end
    look0(19'h00000, 1'b0, 8'd0);
    total++;
    if ({s0_found, s0_index, s0_v} !== {1'b1, 4'd0, 1'b0}) begin
      bad++; $display("FAIL zero_tag got f=%b i=%0d v=%b exp 1/0/0", s0_found, s0_index, s0_v);
    end
  endtask

  initial begin
    reset = 1'b1;
    s0_req = 0; s0_hold = 0; s0_vpn2 = '0; s0_odd_page = 0; s0_asid = '0;
    s1_req = 0; s1_hold = 0; s1_vpn2 = '0; s1_odd_page = 0; s1_asid = '0;
    we = 0; r_index = '0;
    set_w(4'd0, 19'h0, 8'h0, 1'b0, 20'h0, 3'd0, 1'b0, 20'h0, 3'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_lookup();
    test_global();
    test_hazard();
    test_stale();
    test_dup();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlb.md
Name: tlb

Overview:
- Joint TLB array with 16 entries (parameterised) that sits directly beside cp0.
- Consumes cp0's write port (tlbwi/tlbwr) and supplies cp0's read port (tlbr) and tlbp_result.
- Provides two registered lookup ports: s0 for the fetch stage and s1 for the memory stage and tlbp.
- Lookup results appear one cycle after a request, with hold-on-stall and a stale flag when the array changes under a held result.

Parameters:
- TLBNUM, 16, number of entries.
- TLBNUM_WIDTH, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s{0,1}_req  in  1  launch a lookup this cycle.
- s{0,1}_hold  in  1  consumer stalled; keep the registered result.
- s{0,1}_vpn2  in  19  VA[31:13].
- s{0,1}_odd_page  in  1  VA[12].
- s{0,1}_asid  in  8  current ASID.
- s{0,1}_valid  out  1  registered result present.
- s{0,1}_found  out  1  hit.
- s{0,1}_index  out  TLBNUM_WIDTH  hit index.
- s{0,1}_pfn  out  20  selected page PFN.
- s{0,1}_c  out  3  selected page cache attribute.
- s{0,1}_d  out  1  selected page dirty bit.
- s{0,1}_v  out  1  selected page valid bit.
- s{0,1}_stale  out  1  array written while the result was held.
- tlbp_result  out  TLBNUM_WIDTH+1  {~s1_found, s1_index}.
- we  in  1  write strobe.
- w_index  in  TLBNUM_WIDTH  write index.
- w_vpn2  in  19  write VPN2.
- w_asid  in  8  write ASID.
- w_g  in  1  write global bit.
- w_pfn0, w_c0, w_d0, w_v0  in  20/3/1/1  write even page.
- w_pfn1, w_c1, w_d1, w_v1  in  20/3/1/1  write odd page.
- r_index  in  TLBNUM_WIDTH  read index.
- r_vpn2, r_asid, r_g  out  19/8/1  read entry tag.
- r_pfn0, r_c0, r_d0, r_v0  out  20/3/1/1  read even page.
- r_pfn1, r_c1, r_d1, r_v1  out  20/3/1/1  read odd page.
- s{0,1}_multi_hit  out  1  only present with TLB_MULTI_HIT_EN.

Behaviour:
- Reset (async): all entries get v0=v1=0, g=0, vpn2=0, asid=0. All s*_valid, s*_found, s*_stale and s*_multi_hit are 0. All other s* outputs are 0.
- Match rule: entry i matches when vpn2[i]==s_vpn2 and (g[i] or asid[i]==s_asid).
  - found = OR of all matches.
  - index = lowest matching i.
  - Page fields come from the odd half when odd_page=1, otherwise the even half.
- Latency: a request in cycle N compares against array contents as they stand before the edge ending cycle N. Results are registered at that edge and visible in cycle N+1.
- Write vs search in the same cycle: the search sees the old contents. The write takes effect from cycle N+1.
- Per-port result register:
  - If hold=1, the register is held and req is ignored.
  - Otherwise, req=1 loads a new result and sets valid=1.
  - Otherwise (req=0, hold=0), valid is cleared; the data fields are don't-care.
- stale:
  - Sets when we=1 in any cycle where the port has valid=1 and hold=1.
  - Clears on any result load, or when valid drops.
  - While stale, the data is left unchanged; the consumer must reissue.
- Write: on the clock edge with we=1, entry[w_index] takes all w_* fields. No bypass to the read port in the same cycle.
- Read port: combinational from the array at r_index. This is required by cp0, which samples r_* in the same cycle as tlbr.
- tlbp_result: taken from the s1 registered result, with MSB=1 on a miss. The index field is 0 on a miss.
- Duplicate matches without TLB_MULTI_HIT_EN: the lowest index wins silently.

Optional Feature:
- TLB_MULTI_HIT_EN defined:
  - Adds s0_multi_hit and s1_multi_hit, registered alongside found.
  - Each is 1 when two or more entries match the lookup.
  - found and index are unchanged (lowest index still wins).
- TLB_MULTI_HIT_EN undefined: these ports do not exist and the popcount logic is absent.

Decomposition:
- Shared header tlb.vh holds:
  - Cache attribute codes (UNCACHED=2, CACHED=3), common with cp0.vh.
  - Field width constants: VPN2_W=19, PFN_W=20, ASID_W=8.
- Sub-module tlb_match, instantiated once per search port.
  - Inputs: array tag vectors and the lookup key.
  - Contents: combinational comparators, priority encoder, page-half mux.
  - Outputs: found, index, page fields, and multi-hit.
- Result registers and stale logic stay in tlb.

Test Plan:
- Write idx 3 (vpn2=0x00012, asid=5, g=0, pfn1=0xABCDE, c1=3, v1=1); s0_req with vpn2=0x00012, odd=1, asid=5 -> next cycle valid=1, found=1, index=3, pfn=0xABCDE, v=1. Same lookup with asid=6 -> found=0.
- Same write but g=1; lookup with asid=0xFF -> found=1. tlbp via s1 -> tlbp_result={0,4'd3}. Missing vpn2 -> tlbp_result[4]=1.
- Same-cycle hazard: we to idx 7 (vpn2=0x40) together with s1_req for vpn2=0x40 -> found=0. Reissue next cycle -> found=1, index=7.
- Hold/stale: s0 result valid, then hold=1 and we=1 for one cycle -> stale=1 and data unchanged. Release hold with req=1 -> stale=0 and fresh result.
- Reset: assert reset asynchronously mid-lookup between clock edges -> valid, found and stale drop immediately. Lookups of previously written entries -> v=0.
- Duplicates: entries 2 and 9 both with vpn2=0x55 -> index=2. With TLB_MULTI_HIT_EN, multi_hit=1.
